align_shift: RTL and testbench

- Two-stage pipelined alignment shifter for the FP adder; sits directly downstream of the operand swap stage.
- Takes the swapped operands (larger operand A, smaller operand B already pre-shifted to FW+2 bits) and the exponent difference.
- Right-shifts B's significand by the difference and produces a sticky bit.
- Feeds the significand add/subtract stage through a valid/ready handshake.

---
 rtl/align_shift.sv | 133 +++++++++++++
 tb/tb_align_shift.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/align_shift.sv
// align_shift: two-stage alignment shifter for the FP adder.
// Stage 1 does a byte-granular coarse shift of B (or saturates to zero for
// large differences), stage 2 finishes the 0..7 bit fine shift. Both stages
// fold every bit shifted out of B into a single sticky bit.
module align_shift #(
    parameter int EW = 11,
    parameter int FW = 53
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic          sa2,
    input  logic [FW-1:0] fa2,
    input  logic          sb2,
    input  logic [FW+1:0] fb2,
    input  logic [EW-1:0] ea,
    input  logic [EW-1:0] as,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          sa3,
    output logic [FW-1:0] fa3,
    output logic          sb3,
    output logic [FW+2:0] fb3,
    output logic [EW-1:0] ea3
);

    localparam int BW = FW + 2;

    // Stage valids.
    logic v1, v2;
    logic s1_en, s2_en;

    // Stage 1 registers.
    logic [BW-1:0] r1_val;
    logic          r1_st;
    logic [2:0]    r1_fsh;
    logic          r1_sa;
    logic [FW-1:0] r1_fa;
    logic          r1_sb;
    logic [EW-1:0] r1_ea;

    // Stage 1 combinational results.
    logic          sat;
    logic [5:0]    csh;
    logic [BW-1:0] c_mask;
    logic [BW-1:0] c_val;
    logic          c_st;

    // Stage 2 combinational results.
    logic [BW-1:0] f_mask;
    logic [BW-1:0] f_val;
    logic          f_st;

    // A stage advances when it is empty or the stage after it advances, so
    // bubbles collapse under backpressure. in_ready never depends on in_valid.
    always_comb begin
        s2_en    = !v2 || out_ready;
        s1_en    = !v1 || s2_en;
        in_ready = s1_en;
    end

    // Coarse shift by a multiple of 8; differences of 64 or more flush B.
    always_comb begin
        sat    = |as[EW-1:6];
        csh    = {as[5:3], 3'b000};
        c_mask = ~({BW{1'b1}} << csh);
        c_val  = '0;
        c_st   = 1'b0;
        if (sat) begin
            c_st = |fb2;
        end else begin
            c_val = fb2 >> csh;
            c_st  = |(fb2 & c_mask);
        end
    end

    // Stage 1 register: capture coarse result and pass-through fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1     <= 1'b0;
            r1_val <= '0;
            r1_st  <= 1'b0;
            r1_fsh <= '0;
            r1_sa  <= 1'b0;
            r1_fa  <= '0;
            r1_sb  <= 1'b0;
            r1_ea  <= '0;
        end else if (s1_en) begin
            v1 <= in_valid;
            if (in_valid) begin
                r1_val <= c_val;
                r1_st  <= c_st;
                r1_fsh <= as[2:0];
                r1_sa  <= sa2;
                r1_fa  <= fa2;
                r1_sb  <= sb2;
                r1_ea  <= ea;
            end
        end
    end

    // Fine shift by 0..7; sticky accumulates both stages' lost bits.
    always_comb begin
        f_mask = ~({BW{1'b1}} << r1_fsh);
        f_val  = r1_val >> r1_fsh;
        f_st   = r1_st | (|(r1_val & f_mask));
    end

    // Stage 2 register drives the outputs directly, so they hold under stall.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2  <= 1'b0;
            sa3 <= 1'b0;
            fa3 <= '0;
            sb3 <= 1'b0;
            fb3 <= '0;
            ea3 <= '0;
        end else if (s2_en) begin
            v2 <= v1;
            if (v1) begin
                sa3 <= r1_sa;
                fa3 <= r1_fa;
                sb3 <= r1_sb;
                fb3 <= {f_val, f_st};
                ea3 <= r1_ea;
            end
        end
    end

    assign out_valid = v2;

endmodule

// File: tb/tb_align_shift.sv
// Bench for align_shift: directed vectors with hand-computed fb3, a
// scoreboard queue filled on input transfer and drained by a monitor.
module tb_align_shift;

    localparam int EW = 11;
    localparam int FW = 53;
    localparam int NV = 13;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic          sa2;
    logic [FW-1:0] fa2;
    logic          sb2;
    logic [FW+1:0] fb2;
    logic [EW-1:0] ea;
    logic [EW-1:0] as;
    logic          out_valid;
    logic          out_ready;
    logic          sa3;
    logic [FW-1:0] fa3;
    logic          sb3;
    logic [FW+2:0] fb3;
    logic [EW-1:0] ea3;

    typedef struct packed {
        logic          sa;
        logic [FW-1:0] fa;
        logic          sb;
        logic [FW+2:0] fb3;
        logic [EW-1:0] ea;
    } exp_t;

    exp_t q[$];
    int compared   = 0;
    int mismatched = 0;
    int pops       = 0;

    logic [FW+1:0] v_fb[NV];
    logic [EW-1:0] v_as[NV];
    logic [FW+2:0] v_ex[NV];

    align_shift #(.EW(EW), .FW(FW)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .sa2(sa2), .fa2(fa2), .sb2(sb2), .fb2(fb2), .ea(ea), .as(as),
        .out_valid(out_valid), .out_ready(out_ready),
        .sa3(sa3), .fa3(fa3), .sb3(sb3), .fb3(fb3), .ea3(ea3)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s: got %h expected %h", nm, act, req);
        end
    endtask

    // Drive one vector and hold it until accepted; leaves in_valid high so the
    // next call (or idle) can follow back-to-back.
    task automatic send(input int i);
        exp_t e;
        int n;
        @(posedge clk); #1;
        in_valid = 1'b1;
        fb2 = v_fb[i];
        as  = v_as[i];
        sa2 = i[0];
        sb2 = ~i[0];
        fa2 = 53'h10_0000_0000_0000 + 53'(i);
        ea  = 11'h400 + 11'(i);
        e.sa = sa2; e.fa = fa2; e.sb = sb2; e.fb3 = v_ex[i]; e.ea = ea;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            compared++;
            mismatched++;
            $display("FAIL send_timeout: vector %0d never accepted, in_ready %b required 1", i, in_ready);
        end else begin
            q.push_back(e);
        end
    endtask

    task automatic idle(input int c);
        for (int k = 0; k < c; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic set_ready(input logic r);
        @(posedge clk); #1;
        out_ready = r;
    endtask

    // Monitor: pop and compare on every output transfer; check hold stability.
    initial begin
        exp_t e;
        exp_t act;
        exp_t held;
        logic hold_v;
        hold_v = 1'b0;
        held = '0;
        forever begin
            @(negedge clk);
            act.sa = sa3; act.fa = fa3; act.sb = sb3; act.fb3 = fb3; act.ea = ea3;
            if (rst) begin
                hold_v = 1'b0;
            end else begin
                if (hold_v) begin
                    compared++;
                    if (!out_valid || act !== held) begin
                        mismatched++;
                        $display("FAIL stall_stable: got v=%b fb3=%h expected v=1 fb3=%h", out_valid, fb3, held.fb3);
                    end
                end
                if (out_valid && out_ready) begin
                    compared++;
                    pops++;
                    if (q.size() == 0) begin
                        mismatched++;
                        $display("FAIL unexpected_out: got fb3=%h expected no output", fb3);
                    end else begin
                        e = q.pop_front();
                        if (act !== e) begin
                            mismatched++;
                            $display("FAIL out_data: got sa=%b fa=%h sb=%b fb3=%h ea=%h expected sa=%b fa=%h sb=%b fb3=%h ea=%h",
                                     act.sa, act.fa, act.sb, act.fb3, act.ea, e.sa, e.fa, e.sb, e.fb3, e.ea);
                        end
                    end
                end
                hold_v = out_valid && !out_ready;
                held = act;
            end
        end
    end

    initial begin
        logic [FW+1:0] ones;
        int p0;
        int n;
        ones = '1;
        v_fb[0]  = 55'h40_0000_0000_0000; v_as[0]  = 11'd1;    v_ex[0]  = 56'h40_0000_0000_0000;
        v_fb[1]  = 55'h5;                 v_as[1]  = 11'd3;    v_ex[1]  = 56'h1;
        v_fb[2]  = 55'h8;                 v_as[2]  = 11'd3;    v_ex[2]  = 56'h2;
        v_fb[3]  = 55'h1;                 v_as[3]  = 11'h7FF;  v_ex[3]  = 56'h1;
        v_fb[4]  = 55'h0;                 v_as[4]  = 11'h7FF;  v_ex[4]  = 56'h0;
        v_fb[5]  = ones;                  v_as[5]  = 11'd64;   v_ex[5]  = 56'h1;
        v_fb[6]  = ones;                  v_as[6]  = 11'd56;   v_ex[6]  = 56'h1;
        v_fb[7]  = 55'h1234;              v_as[7]  = 11'd0;    v_ex[7]  = 56'h2468;
        v_fb[8]  = ones;                  v_as[8]  = 11'd54;   v_ex[8]  = 56'h3;
        v_fb[9]  = 55'h100;               v_as[9]  = 11'd9;    v_ex[9]  = 56'h1;
        v_fb[10] = 55'hFF00;              v_as[10] = 11'd8;    v_ex[10] = 56'h1FE;
        v_fb[11] = 55'h0;                 v_as[11] = 11'd0;    v_ex[11] = 56'h0;
        v_fb[12] = 55'h0;                 v_as[12] = 11'd30;   v_ex[12] = 56'h0;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        sa2 = 1'b0; fa2 = '0; sb2 = 1'b0; fb2 = '0; ea = '0; as = '0;
        #3;
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_fb3", 64'(fb3), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("reset_in_ready", 64'(in_ready), 64'd1);

        // Latency: output appears after exactly two edges.
        send(0);
        idle(1);
        @(negedge clk);
        chk("latency_c1", 64'(out_valid), 64'd0);
        @(negedge clk);
        chk("latency_c2", 64'(out_valid), 64'd1);

        // Continuous stream of the arithmetic vectors.
        for (int i = 1; i < 8; i++) send(i);
        idle(4);

        // Backpressure: 4 back-to-back items, 3 stalled cycles.
        set_ready(1'b0);
        fork
            begin
                for (int i = 8; i < 12; i++) send(i);
                idle(1);
            end
            begin
                n = 0;
                @(negedge clk);
                while (!out_valid && n < 20) begin
                    @(negedge clk);
                    n++;
                end
                chk("bp_out_valid", 64'(out_valid), 64'd1);
                chk("bp_in_ready_full", 64'(in_ready), 64'd0);
                repeat (2) @(negedge clk);
                set_ready(1'b1);
            end
        join
        idle(6);

        // Bubble collapse: 1,0,1 with out_ready low, then release.
        set_ready(1'b0);
        p0 = pops;
        send(12);
        idle(1);
        send(0);
        idle(1);
        @(negedge clk);
        chk("bubble_in_ready", 64'(in_ready), 64'd0);
        chk("bubble_out_valid", 64'(out_valid), 64'd1);
        repeat (2) @(negedge clk);
        set_ready(1'b1);
        repeat (6) @(negedge clk);
        chk("bubble_out_count", 64'(pops - p0), 64'd2);

        // Async reset with two items in flight.
        set_ready(1'b0);
        send(1);
        send(2);
        idle(1);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midreset_out_valid", 64'(out_valid), 64'd0);
        chk("midreset_fb3", 64'(fb3), 64'd0);
        q.delete();
        p0 = pops;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("postreset_in_ready", 64'(in_ready), 64'd1);
        repeat (6) @(negedge clk);
        chk("postreset_no_stale", 64'(pops - p0), 64'd0);

        // Final drain check.
        n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("queue_empty", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
